// File: rtl/led_bar_sequencer.sv
// LED bar driver: fuel-gauge pass-through in IDLE, blink (PBEST) and sweep (GBEST) animations.
// Optional feature: define LED_GBEST_PREEMPT_EN to let new_gbest restart a running PBEST animation.
module led_bar_sequencer #(
    parameter int N_LEDS   = 10,
    parameter int STEP_W   = 2,
    parameter int TICK_DIV = 12500000,
    parameter int N_STEPS  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_LEDS-1:0] fuel_in,
    input  logic [2:0]        disp_mode,
    input  logic              new_pbest,
    input  logic              new_gbest,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy,
    output logic [1:0]        dbgState
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PBEST = 2'd1,
        GBEST = 2'd2
    } state_t;

    localparam int                PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [N_LEDS-1:0] ALL_ONES  = '1;
    localparam logic [N_LEDS-1:0] FILL_MASK = ~(ALL_ONES >> STEP_W);
    localparam logic [7:0]        LAST_STEP = 8'(N_STEPS - 1);

    state_t              state;
    state_t              stateNext;
    logic [PRESC_W-1:0]  prescCnt;
    logic [7:0]          stepCnt;
    logic                animActive;
    logic                tick;
    logic                lastTick;
    logic                preempt;
    logic                startAnim;
    logic [N_LEDS-1:0]   ledNext;
    logic [N_LEDS-1:0]   sweepNext;

    assign animActive = (state == PBEST) || (state == GBEST);
    assign tick       = animActive && (prescCnt == PRESC_MAX);
    assign lastTick   = tick && (stepCnt == LAST_STEP);

`ifdef LED_GBEST_PREEMPT_EN
    assign preempt = (state == PBEST) && new_gbest;
`else
    assign preempt = 1'b0;
`endif

    // Animation (re)start: IDLE request or a preempting global best.
    assign startAnim = ((state == IDLE) && (new_pbest || new_gbest)) || preempt;

    // Sweep: ones enter from the MSB; a full bar wraps back to dark.
    assign sweepNext = (led_out == ALL_ONES) ? '0 : ((led_out >> STEP_W) | FILL_MASK);

    assign dbgState = state;

    // State register plus registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            led_out <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= stateNext;
            led_out <= ledNext;
            busy    <= (stateNext == PBEST) || (stateNext == GBEST);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescCnt <= '0;
            stepCnt  <= '0;
        end else if (startAnim || (stateNext == IDLE)) begin
            prescCnt <= '0;
            stepCnt  <= '0;
        end else if (tick) begin
            prescCnt <= '0;
            stepCnt  <= stepCnt + 8'd1;
        end else begin
            prescCnt <= prescCnt + PRESC_W'(1);
        end
    end

    always_comb begin
        stateNext = IDLE;
        case (state)
            IDLE: begin
                if (new_gbest)      stateNext = GBEST;
                else if (new_pbest) stateNext = PBEST;
                else                stateNext = IDLE;
            end
            PBEST: begin
                if (preempt)       stateNext = GBEST;
                else if (lastTick) stateNext = IDLE;
                else               stateNext = PBEST;
            end
            GBEST: begin
                if (lastTick) stateNext = IDLE;
                else          stateNext = GBEST;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ledNext = '0;
        case (state)
            IDLE: begin
                if (startAnim)             ledNext = ALL_ONES;
                else if (disp_mode == 3'd0) ledNext = '0;
                else                       ledNext = fuel_in;
            end
            PBEST: begin
                if (preempt)   ledNext = ALL_ONES;
                else if (tick) ledNext = ~led_out;
                else           ledNext = led_out;
            end
            GBEST: begin
                if (tick) ledNext = sweepNext;
                else      ledNext = led_out;
            end
            default: ledNext = '0;
        endcase
    end

endmodule
